// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, reads imem and buffers {pc, word} in a prefetch FIFO for decode.
// Define IMEM_FETCH_BOUND_CHECK_EN to stop fetching after the last imem word (HALT state, halted output).
module imem_fetch_ctrl #(
    parameter int N         = 32,
    parameter int PC_W      = 64,
    parameter int DEPTH     = 4,
    parameter int ROM_WORDS = 128
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         fetch_en,
    input  logic                         redirect,
    input  logic [PC_W-1:0]              redirect_pc,
    output logic [$clog2(ROM_WORDS)-1:0] imem_addr,
    output logic                         imem_enable,
    input  logic [N-1:0]                 imem_q,
    output logic                         if_valid,
    input  logic                         if_ready,
    output logic [N-1:0]                 if_instr,
    output logic [PC_W-1:0]              if_pc,
    output logic                         halted,
    output logic [$clog2(DEPTH):0]       count
);
    localparam int AW = $clog2(ROM_WORDS);
    localparam int PW = $clog2(DEPTH);

`ifdef IMEM_FETCH_BOUND_CHECK_EN
    typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;
`else
    typedef enum logic [1:0] {IDLE, FETCH} state_t;
`endif

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc;
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [N-1:0]    mem_instr [DEPTH];
    logic [PC_W-1:0] mem_pc    [DEPTH];
    logic            push, pop;

    assign imem_enable = (state == FETCH);
    assign imem_addr   = pc[AW+1:2];
    assign if_valid    = (count != '0);
    assign if_instr    = mem_instr[rd_ptr];
    assign if_pc       = mem_pc[rd_ptr];

    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign pop  = if_valid && if_ready;
    assign push = (state == FETCH) && ((count < (PW+1)'(DEPTH)) || pop);

`ifdef IMEM_FETCH_BOUND_CHECK_EN
    logic at_bound;
    assign at_bound = (pc[PC_W-1:2] == (PC_W-2)'(ROM_WORDS - 1));
`endif

    always_comb begin
        state_nxt = state;
        if (redirect) begin
            state_nxt = fetch_en ? FETCH : IDLE;
        end else begin
            case (state)
                IDLE: if (fetch_en) state_nxt = FETCH;
                FETCH: begin
                    if (!fetch_en) state_nxt = IDLE;
`ifdef IMEM_FETCH_BOUND_CHECK_EN
                    if (push && at_bound) state_nxt = HALT;
`endif
                end
                default: state_nxt = state;
            endcase
        end
    end

    // Redirect flushes everything in flight; push/pop of that cycle are dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            pc     <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr[i] <= '0;
                mem_pc[i]    <= '0;
            end
        end else begin
            state <= state_nxt;
            if (redirect) begin
                pc     <= redirect_pc & ~PC_W'(3);
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    mem_pc[wr_ptr]    <= pc;
                    mem_instr[wr_ptr] <= imem_q;
                    wr_ptr            <= wr_ptr + PW'(1);
                    pc                <= pc + PC_W'(4);
                end
                if (pop) rd_ptr <= rd_ptr + PW'(1);
                if (push && !pop)      count <= count + (PW+1)'(1);
                else if (pop && !push) count <= count - (PW+1)'(1);
            end
        end
    end

`ifdef IMEM_FETCH_BOUND_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) halted <= 1'b0;
        else        halted <= (state_nxt == HALT);
    end
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios plus random traffic against an instruction-stream scoreboard.
`timescale 1ns/1ps
module tb_imem_fetch_ctrl;
    localparam int N = 32, PC_W = 64, DEPTH = 4, ROM_WORDS = 128;
    localparam int AW = 7, CW = 3;

    logic            clk = 1'b0;
    logic            reset, fetch_en, redirect, if_ready;
    logic [PC_W-1:0] redirect_pc;
    logic [AW-1:0]   imem_addr;
    logic            imem_enable;
    logic [N-1:0]    imem_q;
    logic            if_valid;
    logic [N-1:0]    if_instr;
    logic [PC_W-1:0] if_pc;
    logic            halted;
    logic [CW-1:0]   count;

    int total = 0, bad = 0;
    bit mon_en = 0, have_prev = 0, prev_redirect = 0;
    int prev_count = 0;
    logic [PC_W-1:0] exp_pc_q[$];
    logic [N-1:0]    exp_instr_q[$];

    imem_fetch_ctrl #(.N(N), .PC_W(PC_W), .DEPTH(DEPTH), .ROM_WORDS(ROM_WORDS)) dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_enable(imem_enable),
        .imem_q(imem_q), .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
        .if_pc(if_pc), .halted(halted), .count(count)
    );

    always #5 clk = ~clk;

    // imem model: word k holds A000_0000 + k
    assign imem_q = 32'hA000_0000 + 32'(imem_addr);

    function automatic logic [N-1:0] word_at(logic [PC_W-1:0] p);
        return 32'hA000_0000 + 32'((p >> 2) % ROM_WORDS);
    endfunction

    task automatic check(string name, logic [PC_W-1:0] act, logic [PC_W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h need %0h", name, act, req);
        end
    endtask

    // Expected decode stream from a fetch target: consecutive words, stopping at the bound when it is enabled.
    task automatic load_stream(logic [PC_W-1:0] start);
        logic [PC_W-1:0] p;
        p = start & ~64'd3;
        exp_pc_q.delete();
        exp_instr_q.delete();
        for (int i = 0; i < 800; i++) begin
            exp_pc_q.push_back(p);
            exp_instr_q.push_back(word_at(p));
`ifdef IMEM_FETCH_BOUND_CHECK_EN
            if (p[PC_W-1:2] == 62'(ROM_WORDS - 1)) break;
`endif
            p = p + 64'd4;
        end
    endtask

    always @(negedge clk) begin
        int cur;
        if (reset && mon_en) begin
            cur = int'(count);
            check("valid_vs_count", if_valid, (count != 0));
            check("count_max", (cur <= DEPTH), 1);
            if (have_prev) begin
                if (prev_redirect) check("flush_count", count, 0);
                else check("count_step", (cur >= prev_count - 1 && cur <= prev_count + 1), 1);
            end
            if (if_valid && if_ready && !redirect) begin
                if (exp_pc_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_output: got pc %0h, need no output", if_pc);
                end else begin
                    check("stream_pc", if_pc, exp_pc_q.pop_front());
                    check("stream_instr", if_instr, exp_instr_q.pop_front());
                end
            end
            have_prev     = 1;
            prev_redirect = redirect;
            prev_count    = cur;
        end else begin
            have_prev = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(logic [PC_W-1:0] t);
        redirect    = 1'b1;
        redirect_pc = t;
        load_stream(t);
        tick();
        redirect    = 1'b0;
    endtask

    task automatic wait_count(int n);
        int k;
        k = 0;
        while (int'(count) != n && k < 30) begin
            tick();
            k++;
        end
        check("wait_count", count, n);
    endtask

    task automatic check_reset_vals(string tag);
        check({tag, "_if_valid"}, if_valid, 0);
        check({tag, "_if_instr"}, if_instr, 0);
        check({tag, "_if_pc"}, if_pc, 0);
        check({tag, "_imem_enable"}, imem_enable, 0);
        check({tag, "_imem_addr"}, imem_addr, 0);
        check({tag, "_halted"}, halted, 0);
        check({tag, "_count"}, count, 0);
    endtask

    initial begin
        logic [PC_W-1:0] t;
        reset = 1'b0; fetch_en = 1'b0; redirect = 1'b0; if_ready = 1'b0; redirect_pc = '0;
        #3;
        check_reset_vals("rst");
        tick();
        tick();
        reset = 1'b1;

        // Streaming from reset
        load_stream(0);
        mon_en   = 1;
        fetch_en = 1'b1;
        if_ready = 1'b1;
        tick();
        check("fetch_entry_enable", imem_enable, 1);
        check("fetch_entry_valid", if_valid, 0);
        check("fetch_entry_addr", imem_addr, 0);
        tick();
        check("first_valid", if_valid, 1);
        check("first_pc", if_pc, 0);
        check("first_instr", if_instr, 32'hA000_0000);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("stream_no_gap", if_valid, 1);
        end
        check("halted_idle", halted, 0);

        // Back-pressure: FIFO fills, PC stops at 16
        if_ready = 1'b0;
        do_redirect(0);
        for (int i = 0; i < 10; i++) tick();
        check("bp_count_full", count, 4);
        check("bp_pc_hold_addr", imem_addr, 4);
        check("bp_enable", imem_enable, 1);
        if_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_drain_no_gap", if_valid, 1);
        end

        // Redirect with count=3
        if_ready = 1'b0;
        do_redirect(64'h80);
        wait_count(3);
        do_redirect(64'h103);
        check("redir_count", count, 0);
        check("redir_valid", if_valid, 0);
        check("redir_addr", imem_addr, 64);
        tick();
        check("redir_valid2", if_valid, 1);
        check("redir_pc", if_pc, 64'h100);
        check("redir_instr", if_instr, 32'hA000_0040);

        // Redirect together with a handshake: head is flushed
        if_ready = 1'b1;
        do_redirect(64'h40);
        tick();
        check("flush_hs_valid", if_valid, 1);
        check("flush_hs_pc", if_pc, 64'h40);

        // Bound / wrap around the top of imem
        do_redirect(64'h1F8);
        check("bound_addr126", imem_addr, 126);
        tick();
        check("bound_addr127", imem_addr, 127);
        tick();
`ifdef IMEM_FETCH_BOUND_CHECK_EN
        check("bound_halted", halted, 1);
        check("bound_enable", imem_enable, 0);
        tick();
        check("bound_drained", count, 0);
        do_redirect(0);
        check("bound_halt_clear", halted, 0);
        check("bound_refetch", imem_enable, 1);
`else
        check("wrap_addr0", imem_addr, 0);
        check("wrap_enable", imem_enable, 1);
        tick();
        tick();
        check("wrap_halted", halted, 0);
        do_redirect(0);
`endif

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            if_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) fetch_en = ~fetch_en;
            if ($urandom_range(0, 24) == 0) begin
                if ($urandom_range(0, 1) != 0) t = {32'($urandom), 32'($urandom)};
                else t = PC_W'($urandom_range(0, 1023));
                do_redirect(t);
            end else begin
                tick();
            end
        end
        if_ready = 1'b1;
        fetch_en = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("rand_drain", count, 0);

        // Asynchronous reset mid-stream
        fetch_en = 1'b1;
        if_ready = 1'b0;
        do_redirect(64'h20);
        wait_count(2);
        #2;
        mon_en = 0;
        reset  = 1'b0;
        #1;
        check_reset_vals("async_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
